// File: rtl/asi_pkg.sv
// Shared types and constants for the ASI read/write arbiter.
package asi_pkg;

  // Arbiter state: no owner, read channel owns the port, write channel owns the port.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RGNT,
    ARB_WGNT
  } ARB_STATE;

  // Encoding of the side chosen by an arbitration decision: 1 = read, 0 = write.
  localparam logic ARB_GRANT_READ = 1'b1;

endpackage

// File: rtl/asi_arb_if.sv
// Bundle between the ASI read/write channels (master) and the arbiter (slave).
//
// Handshake: m_arff_rvalid / m_awff_rvalid are burst-start requests. A request
// is accepted when it is sampled high while the arbiter is idle; acceptance is
// signalled by the matching grant rising on the next cycle, and that grant acts
// as the "ready" for the whole burst. The request may drop once the grant is
// seen. Beats (m_re / m_we) count only while the matching grant is high, and the
// beat carrying the last flag ends the burst; the grant falls on the next cycle.
interface asi_arb_if;
  import asi_pkg::*;

  logic m_arff_rvalid;
  logic m_re;
  logic m_rlast;
  logic m_awff_rvalid;
  logic m_we;
  logic m_wlast;
  logic m_rgranted;
  logic m_wgranted;
  logic arb_starve;

  // Channel side: drives requests and beats, observes grants.
  modport master (
    output m_arff_rvalid, m_re, m_rlast,
    output m_awff_rvalid, m_we, m_wlast,
    input  m_rgranted, m_wgranted, arb_starve
  );

  // Arbiter side: observes requests and beats, drives grants.
  modport slave (
    input  m_arff_rvalid, m_re, m_rlast,
    input  m_awff_rvalid, m_we, m_wlast,
    output m_rgranted, m_wgranted, arb_starve
  );

endinterface

// File: rtl/asi_arb.sv
// Read/write arbiter for the shared user-side memory port behind the ASI
// read and write channels. One side owns the port per burst; fixed priority
// with a starvation limit that hands one burst to the waiting side.
module asi_arb
  import asi_pkg::*;
#(
  parameter int ASI_ARB  = 0,
  parameter int ARB_MAXC = 4,
  parameter int ARB_CW   = (ARB_MAXC < 1) ? 1 : $clog2(ARB_MAXC + 1)
) (
  input  logic      usr_clk,
  input  logic      usr_reset_n,
  asi_arb_if.slave  arb,
  output ARB_STATE  state_o
);

  // Which side wins a contested decision when the limit has not been hit.
  localparam logic PRIO_READ = (ASI_ARB != 0) ? ARB_GRANT_READ : ~ARB_GRANT_READ;
  // The starvation limit is disabled entirely for strict priority.
  localparam bit MAXC_EN = (ARB_MAXC != 0);
  localparam logic [ARB_CW-1:0] MAXC_C = ARB_CW'(ARB_MAXC);

  ARB_STATE          state_q, state_d;
  logic [ARB_CW-1:0] cnt_q, cnt_d;
  logic              starve_q, starve_d;

  logic              grant_side_d;
  logic              starve_hit;
  logic [ARB_CW-1:0] cnt_sat;
  logic              req_r, req_w;
  logic              rel_r, rel_w;

  assign req_r = arb.m_arff_rvalid;
  assign req_w = arb.m_awff_rvalid;
  // Beats are qualified by state below, so out-of-turn beats have no effect.
  assign rel_r = arb.m_re & arb.m_rlast;
  assign rel_w = arb.m_we & arb.m_wlast;

  // Priority side has been granted ARB_MAXC times in a row while the other waited.
  assign starve_hit = MAXC_EN && (cnt_q == MAXC_C);
  // Saturating increment; with ARB_MAXC = 0 this holds the counter at zero.
  assign cnt_sat = (cnt_q == MAXC_C) ? cnt_q : cnt_q + ARB_CW'(1);

  // Next-state decision: arbitrate only from IDLE, release on the last beat.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    grant_side_d = PRIO_READ;
    unique case (state_q)
      ARB_IDLE: begin
        if (req_r && req_w) begin
          if (starve_hit) begin
            grant_side_d = ~PRIO_READ;
            starve_d     = 1'b1;
            cnt_d        = '0;
          end else begin
            grant_side_d = PRIO_READ;
            starve_d     = 1'b0;
            cnt_d        = cnt_sat;
          end
          state_d = (grant_side_d == ARB_GRANT_READ) ? ARB_RGNT : ARB_WGNT;
        end else if (req_r) begin
          // Uncontested grant: either a non-priority grant or a priority grant
          // with nobody waiting, so the run of consecutive grants restarts.
          state_d  = ARB_RGNT;
          starve_d = 1'b0;
          cnt_d    = '0;
        end else if (req_w) begin
          state_d  = ARB_WGNT;
          starve_d = 1'b0;
          cnt_d    = '0;
        end
      end
      ARB_RGNT: begin
        if (rel_r) state_d = ARB_IDLE;
      end
      ARB_WGNT: begin
        if (rel_w) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, consecutive-grant counter and starvation flag registers.
  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // Grants come straight off the state register: glitch-free and mutually exclusive.
  assign arb.m_rgranted = (state_q == ARB_RGNT);
  assign arb.m_wgranted = (state_q == ARB_WGNT);
  assign arb.arb_starve = starve_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_asi_arb.sv
// Directed bench for asi_arb: two instances (write priority with limit 4, and
// strict read priority) driven through their interfaces, with expected grants
// queued as stimulus is issued and popped as the arbiter grants.
module tb_asi_arb;
  import asi_pkg::*;

  localparam logic [2:0] G_R  = 3'b001;  // {starve, wgnt, rgnt}
  localparam logic [2:0] G_W  = 3'b010;
  localparam logic [2:0] G_RS = 3'b101;

  logic     clk;
  logic     rst_n;
  ARB_STATE state_a, state_b;

  int vectors     = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

  asi_arb_if ifa ();
  asi_arb_if ifb ();

  asi_arb #(.ASI_ARB(0), .ARB_MAXC(4)) dut_a (
    .usr_clk     (clk),
    .usr_reset_n (rst_n),
    .arb         (ifa),
    .state_o     (state_a)
  );

  asi_arb #(.ASI_ARB(1), .ARB_MAXC(0)) dut_b (
    .usr_clk     (clk),
    .usr_reset_n (rst_n),
    .arb         (ifb),
    .state_o     (state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] get_obs(input bit sel);
    if (sel) return {ifb.arb_starve, ifb.m_wgranted, ifb.m_rgranted};
    return {ifa.arb_starve, ifa.m_wgranted, ifa.m_rgranted};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit sel, input logic rv, input logic wv);
    if (sel) begin
      ifb.m_arff_rvalid = rv;
      ifb.m_awff_rvalid = wv;
    end else begin
      ifa.m_arff_rvalid = rv;
      ifa.m_awff_rvalid = wv;
    end
  endtask

  task automatic set_beat(input bit sel, input logic re, input logic rl,
                          input logic we, input logic wl);
    if (sel) begin
      ifb.m_re = re; ifb.m_rlast = rl; ifb.m_we = we; ifb.m_wlast = wl;
    end else begin
      ifa.m_re = re; ifa.m_rlast = rl; ifa.m_we = we; ifa.m_wlast = wl;
    end
  endtask

  // Wait (bounded) for a grant, compare it with the scoreboard head, and
  // require the one-cycle request-to-grant latency.
  task automatic wait_grant(input bit sel, input string tag);
    logic [2:0] obs;
    logic [2:0] e;
    int n;
    n = 0;
    tick();
    obs = get_obs(sel);
    while (obs[1:0] == 2'b00 && n < 20) begin
      tick();
      obs = get_obs(sel);
      n++;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 3'bxxx;
    chk({tag, "_grant"}, 32'(obs), 32'(e));
    chk({tag, "_latency"}, n, 0);
  endtask

  // Issue a burst of beats on the granted side; grant must hold until the
  // last beat and drop on the cycle after it.
  task automatic run_beats(input bit sel, input bit rd, input int beats, input string tag);
    logic [2:0] obs;
    for (int i = 0; i < beats; i++) begin
      if (rd) set_beat(sel, 1'b1, (i == beats - 1), 1'b0, 1'b0);
      else    set_beat(sel, 1'b0, 1'b0, 1'b1, (i == beats - 1));
      tick();
      obs = get_obs(sel);
      if (i < beats - 1) chk({tag, "_hold"}, 32'(obs[1:0]), rd ? 32'h1 : 32'h2);
    end
    set_beat(sel, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_release"}, 32'(obs[1:0]), 32'h0);
  endtask

  // Both grants high together is never legal on either instance.
  always @(negedge clk) begin
    chk("one_hot_a", 32'(ifa.m_rgranted & ifa.m_wgranted), 32'h0);
    chk("one_hot_b", 32'(ifb.m_rgranted & ifb.m_wgranted), 32'h0);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] o;
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0); set_beat(0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_req(1, 1'b0, 1'b0); set_beat(1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset, no requests: everything idle for 10 cycles after release.
    repeat (3) tick();
    chk("rst_in_a", 32'(get_obs(0)), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_out_a", 32'(get_obs(0)), 32'h0);
      chk("rst_state_a", 32'(state_a), 32'(ARB_IDLE));
      chk("rst_out_b", 32'(get_obs(1)), 32'h0);
      chk("rst_state_b", 32'(state_b), 32'(ARB_IDLE));
    end

    // Read only, 4 beats; request dropped once granted.
    set_req(0, 1'b1, 1'b0); exp_q.push_back(G_R);
    wait_grant(0, "rd4");
    set_req(0, 1'b0, 1'b0);
    run_beats(0, 1'b1, 4, "rd4");
    chk("rd4_idle", 32'(state_a), 32'(ARB_IDLE));

    // Request held through the release cycle: one IDLE cycle, then regrant.
    set_req(0, 1'b1, 1'b0); exp_q.push_back(G_R);
    wait_grant(0, "rd_held");
    run_beats(0, 1'b1, 1, "rd_held");
    exp_q.push_back(G_R);
    wait_grant(0, "rd_next");
    set_req(0, 1'b0, 1'b0);
    run_beats(0, 1'b1, 1, "rd_next");

    // Out-of-turn beats: ignored in IDLE and ignored during the other grant.
    set_beat(0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("oot_idle", 32'(state_a), 32'(ARB_IDLE));
    set_beat(0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_req(0, 1'b1, 1'b0); exp_q.push_back(G_R);
    wait_grant(0, "oot");
    set_req(0, 1'b0, 1'b0);
    set_beat(0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    o = get_obs(0);
    chk("oot_hold", 32'(o[1:0]), 32'h1);
    set_beat(0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_beats(0, 1'b1, 2, "oot");

    // Single-beat bursts alternating read and write.
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 1'b0); exp_q.push_back(G_R);
      wait_grant(0, "alt_r");
      set_req(0, 1'b0, 1'b0);
      run_beats(0, 1'b1, 1, "alt_r");
      set_req(0, 1'b0, 1'b1); exp_q.push_back(G_W);
      wait_grant(0, "alt_w");
      set_req(0, 1'b0, 1'b0);
      run_beats(0, 1'b0, 1, "alt_w");
    end

    // Write priority, limit 4, both held: W,W,W,W,R*,W,W,W,W,R*.
    for (int k = 0; k < 2; k++) begin
      repeat (4) exp_q.push_back(G_W);
      exp_q.push_back(G_RS);
    end
    set_req(0, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      wait_grant(0, "starve");
      o = get_obs(0);
      run_beats(0, o[0], 2, "starve");
    end
    wait_grant(0, "starve_last");

    // Asynchronous reset in the middle of that forced read burst.
    set_beat(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(get_obs(0)), 32'h0);
    chk("async_rst_state", 32'(state_a), 32'(ARB_IDLE));
    set_req(0, 1'b0, 1'b0);
    set_beat(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_out", 32'(get_obs(0)), 32'h0);

    // Counter restarts at zero after reset: four writes before a forced read.
    repeat (4) exp_q.push_back(G_W);
    exp_q.push_back(G_RS);
    set_req(0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_grant(0, "post_rst");
      o = get_obs(0);
      run_beats(0, o[0], 1, "post_rst");
    end
    set_req(0, 1'b0, 1'b0);

    // Strict read priority: 8 bursts with both held, all reads.
    repeat (8) exp_q.push_back(G_R);
    set_req(1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_grant(1, "strict");
      o = get_obs(1);
      run_beats(1, o[0], 2, "strict");
    end
    set_req(1, 1'b0, 1'b0);
    tick();

    chk("sb_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
